// File: rtl/axi4stream_wr_arbiter.sv
// axi4stream_wr_arbiter
//   Shares one downstream AW+W write path among NUM_PORTS requesters.
//   Round-robin arbitration per burst; a grant is held from arbitration until
//   the WLAST beat of that requester's burst is accepted downstream. All
//   downstream outputs are combinational muxes of the registered grant; the
//   downstream register slice provides timing isolation.
//
// Ports
//   CLK_I, RSTN_I                  clock, synchronous active-low reset
//   S_AW{LEN,SIZE,VALID}/S_AWREADY per-requester address channels (packed)
//   S_W{VALID,DATA,STRB,LAST}/S_WREADY per-requester write data (packed)
//   M_AW{PORT,LEN,SIZE,VALID}/M_AWREADY downstream address channel
//   M_W{VALID,DATA,STRB,LAST}/M_WREADY  downstream write data channel
//   GRANT_O  one-hot grant (0 when idle)
//   BUSY_O   high in ADDR and DATA
//   ERR_O    sticky burst-length error
//
// Optional feature macro: AXI4STREAM_WR_ARB_LENCHK_EN
//   Defined: beat counter checks each burst's WLAST position against the
//   latched AWLEN and sets ERR_O (sticky) on a mismatch.
//   Undefined: no counter, ERR_O tied low.

module axi4stream_wr_arbiter #(
  parameter int NUM_PORTS    = 4,
  parameter int AWPORT_WIDTH = 2,
  parameter int AWLEN_WIDTH  = 16,
  parameter int AWSIZE_WIDTH = 16,
  parameter int WIDTH        = 256
) (
  input  logic                              CLK_I,
  input  logic                              RSTN_I,
  input  logic [NUM_PORTS*AWLEN_WIDTH-1:0]  S_AWLEN,
  input  logic [NUM_PORTS*AWSIZE_WIDTH-1:0] S_AWSIZE,
  input  logic [NUM_PORTS-1:0]              S_AWVALID,
  output logic [NUM_PORTS-1:0]              S_AWREADY,
  input  logic [NUM_PORTS-1:0]              S_WVALID,
  output logic [NUM_PORTS-1:0]              S_WREADY,
  input  logic [NUM_PORTS*WIDTH-1:0]        S_WDATA,
  input  logic [NUM_PORTS*WIDTH/8-1:0]      S_WSTRB,
  input  logic [NUM_PORTS-1:0]              S_WLAST,
  output logic [AWPORT_WIDTH-1:0]           M_AWPORT,
  output logic [AWLEN_WIDTH-1:0]            M_AWLEN,
  output logic [AWSIZE_WIDTH-1:0]           M_AWSIZE,
  output logic                              M_AWVALID,
  input  logic                              M_AWREADY,
  output logic                              M_WVALID,
  input  logic                              M_WREADY,
  output logic [WIDTH-1:0]                  M_WDATA,
  output logic [WIDTH/8-1:0]                M_WSTRB,
  output logic                              M_WLAST,
  output logic [NUM_PORTS-1:0]              GRANT_O,
  output logic                              BUSY_O,
  output logic                              ERR_O
);

  localparam int IDXW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int SW   = WIDTH / 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [IDXW-1:0]      ptr_q, ptr_d;
  logic [IDXW-1:0]      gidx_q, gidx_d;
  logic [NUM_PORTS-1:0] grant_q, grant_d;

  // Per-requester views of the packed input buses
  logic [AWLEN_WIDTH-1:0]  awlen_a  [NUM_PORTS];
  logic [AWSIZE_WIDTH-1:0] awsize_a [NUM_PORTS];
  logic [WIDTH-1:0]        wdata_a  [NUM_PORTS];
  logic [SW-1:0]           wstrb_a  [NUM_PORTS];

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_unpack
    assign awlen_a[p]  = S_AWLEN[p*AWLEN_WIDTH +: AWLEN_WIDTH];
    assign awsize_a[p] = S_AWSIZE[p*AWSIZE_WIDTH +: AWSIZE_WIDTH];
    assign wdata_a[p]  = S_WDATA[p*WIDTH +: WIDTH];
    assign wstrb_a[p]  = S_WSTRB[p*SW +: SW];
  end

  // Round-robin pick: walk offsets from highest to lowest so the candidate
  // closest to ptr (searching upward with wrap) is the one left standing.
  logic            pick_vld;
  logic [IDXW-1:0] pick_idx;
  logic [IDXW-1:0] cand;

  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      cand = IDXW'((int'(ptr_q) + i) % NUM_PORTS);
      if (S_AWVALID[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  logic in_addr, in_data, aw_hs, wlast_hs;
  assign in_addr  = (state_q == ST_ADDR);
  assign in_data  = (state_q == ST_DATA);
  assign aw_hs    = in_addr & M_AWVALID & M_AWREADY;
  assign wlast_hs = in_data & M_WVALID & M_WREADY & M_WLAST;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    grant_d = grant_q;
    case (state_q)
      ST_IDLE: if (pick_vld) begin
        state_d = ST_ADDR;
        gidx_d  = pick_idx;
        grant_d = {{(NUM_PORTS-1){1'b0}}, 1'b1} << pick_idx;
      end
      ST_ADDR: if (aw_hs) state_d = ST_DATA;
      ST_DATA: if (wlast_hs) begin
        state_d = ST_IDLE;
        grant_d = '0;
        ptr_d   = (gidx_q == IDXW'(NUM_PORTS - 1)) ? '0 : gidx_q + 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge CLK_I) begin
    if (!RSTN_I) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      gidx_q  <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      grant_q <= grant_d;
    end
  end

  // Downstream muxes; everything reads zero while idle
  always_comb begin
    M_AWPORT  = '0;
    M_AWLEN   = '0;
    M_AWSIZE  = '0;
    M_AWVALID = 1'b0;
    S_AWREADY = '0;
    M_WVALID  = 1'b0;
    M_WDATA   = '0;
    M_WSTRB   = '0;
    M_WLAST   = 1'b0;
    S_WREADY  = '0;
    if (in_addr | in_data) begin
      M_AWPORT = AWPORT_WIDTH'(gidx_q);
      M_AWLEN  = awlen_a[gidx_q];
      M_AWSIZE = awsize_a[gidx_q];
    end
    if (in_addr) begin
      M_AWVALID = S_AWVALID[gidx_q];
      S_AWREADY = grant_q & {NUM_PORTS{M_AWREADY}};
    end
    if (in_data) begin
      M_WVALID = S_WVALID[gidx_q];
      M_WDATA  = wdata_a[gidx_q];
      M_WSTRB  = wstrb_a[gidx_q];
      M_WLAST  = S_WLAST[gidx_q];
      S_WREADY = grant_q & {NUM_PORTS{M_WREADY}};
    end
  end

  assign GRANT_O = grant_q;
  assign BUSY_O  = in_addr | in_data;

`ifdef AXI4STREAM_WR_ARB_LENCHK_EN
  logic                   w_hs;
  logic [AWLEN_WIDTH:0]   cnt_q;
  logic [AWLEN_WIDTH-1:0] len_q;
  logic                   err_q;

  assign w_hs = in_data & M_WVALID & M_WREADY;

  // A beat is in error when its WLAST disagrees with being beat AWLEN:
  // early WLAST, or reaching AWLEN+1 beats without WLAST.
  always_ff @(posedge CLK_I) begin
    if (!RSTN_I) begin
      cnt_q <= '0;
      len_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (aw_hs) begin
        len_q <= M_AWLEN;
        cnt_q <= '0;
      end else if (w_hs) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (w_hs && (M_WLAST != (cnt_q == {1'b0, len_q}))) err_q <= 1'b1;
    end
  end

  assign ERR_O = err_q;
`else
  assign ERR_O = 1'b0;
`endif

endmodule

// File: tb/tb_axi4stream_wr_arbiter.sv
// Self-checking bench for axi4stream_wr_arbiter. Requesters are modelled as
// bursts (len, beat index, sequence number); the reference tracks which
// requester owns the path, whether its address has gone, and the round-robin
// pointer, and predicts every output each cycle.
module tb_axi4stream_wr_arbiter;
  localparam int N = 4, PW = 2, LW = 16, ZW = 16, W = 256, SW = 32;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic [N*LW-1:0] S_AWLEN;
  logic [N*ZW-1:0] S_AWSIZE;
  logic [N-1:0]    S_AWVALID, S_AWREADY, S_WVALID, S_WREADY, S_WLAST;
  logic [N*W-1:0]  S_WDATA;
  logic [N*SW-1:0] S_WSTRB;
  logic [PW-1:0]   M_AWPORT;
  logic [LW-1:0]   M_AWLEN;
  logic [ZW-1:0]   M_AWSIZE;
  logic            M_AWVALID, M_AWREADY, M_WVALID, M_WREADY, M_WLAST;
  logic [W-1:0]    M_WDATA;
  logic [SW-1:0]   M_WSTRB;
  logic [N-1:0]    GRANT_O;
  logic            BUSY_O, ERR_O;

  axi4stream_wr_arbiter dut (
    .CLK_I(clk), .RSTN_I(rstn),
    .S_AWLEN(S_AWLEN), .S_AWSIZE(S_AWSIZE), .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY),
    .S_WVALID(S_WVALID), .S_WREADY(S_WREADY), .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB),
    .S_WLAST(S_WLAST), .M_AWPORT(M_AWPORT), .M_AWLEN(M_AWLEN), .M_AWSIZE(M_AWSIZE),
    .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY), .M_WVALID(M_WVALID), .M_WREADY(M_WREADY),
    .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB), .M_WLAST(M_WLAST),
    .GRANT_O(GRANT_O), .BUSY_O(BUSY_O), .ERR_O(ERR_O)
  );

  int checks = 0, failures = 0;

  // requester state
  bit act[N], aw_on[N], aw_dn[N], w_on[N], early[N];
  int len[N], siz[N], beat[N], seq[N], badlast[N], wait_b[N];
  // reference state
  int m_own = -1, m_rr = 0;
  bit m_awd = 0, m_err = 0;
  int glog[$];
  // stimulus knobs
  int rdy_mode = 0;      // 0: ready=1, 1: random, 2: W ready toggles
  bit auto_rq = 0, auto_len0 = 0, rnd_w = 0, tog = 1'b1;
  int beats_p1 = 0;

  function automatic logic [31:0] word(int p, int s, int b);
    return (32'(p) << 28) ^ (32'(s) << 8) ^ 32'(b) ^ 32'hA5C3_0000;
  endfunction

  function automatic bit is_last(int p);
    return (badlast[p] >= 0) ? (beat[p] == badlast[p]) : (beat[p] == len[p]);
  endfunction

  function automatic bit any_act();
    for (int p = 0; p < N; p++) if (act[p]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic chk(string tag, logic [255:0] obs, logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start(int p, int l, int bl, bit e, bit awnow);
    act[p] = 1; len[p] = l; siz[p] = int'($urandom_range(0, 65535)); beat[p] = 0;
    badlast[p] = bl; early[p] = e; aw_on[p] = awnow; w_on[p] = e; aw_dn[p] = 0; wait_b[p] = 0;
  endtask

  task automatic drive();
    for (int p = 0; p < N; p++) begin
      S_AWVALID[p] = aw_on[p];
      S_AWLEN[p*LW +: LW] = LW'(len[p]);
      S_AWSIZE[p*ZW +: ZW] = ZW'(siz[p]);
      S_WVALID[p] = w_on[p];
      S_WDATA[p*W +: W] = {8{word(p, seq[p], beat[p])}};
      S_WSTRB[p*SW +: SW] = word(p, seq[p], beat[p]) ^ 32'h0F0F_F0F0;
      S_WLAST[p] = is_last(p);
    end
    case (rdy_mode)
      0: begin M_AWREADY = 1'b1; M_WREADY = 1'b1; end
      1: begin M_AWREADY = ($urandom_range(0, 3) != 0); M_WREADY = ($urandom_range(0, 3) != 0); end
      default: begin M_AWREADY = 1'b1; M_WREADY = tog; tog = ~tog; end
    endcase
  endtask

  task automatic check_outputs();
    int o = m_own;
    int oi = (m_own < 0) ? 0 : m_own;
    bit ia = (o >= 0) && !m_awd;
    bit id = (o >= 0) && m_awd;
    logic [N-1:0] oh = (o >= 0) ? (4'b0001 << oi) : 4'b0000;
    chk("grant", GRANT_O, oh);
    chk("busy", BUSY_O, o >= 0);
    chk("awvalid", M_AWVALID, ia ? aw_on[oi] : 1'b0);
    chk("awready", S_AWREADY, (ia && M_AWREADY) ? oh : 4'b0000);
    chk("wvalid", M_WVALID, id ? w_on[oi] : 1'b0);
    chk("wready", S_WREADY, (id && M_WREADY) ? oh : 4'b0000);
    chk("err", ERR_O, m_err);
    if (ia) begin
      chk("awport", M_AWPORT, oi);
      chk("awlen", M_AWLEN, len[oi]);
      chk("awsize", M_AWSIZE, siz[oi]);
    end
    if (id && w_on[oi]) begin
      chk("wdata", M_WDATA, {8{word(oi, seq[oi], beat[oi])}});
      chk("wstrb", M_WSTRB, word(oi, seq[oi], beat[oi]) ^ 32'h0F0F_F0F0);
      chk("wlast", M_WLAST, is_last(oi));
    end
    if (o < 0) begin
      chk("idle_aw", {M_AWPORT, M_AWLEN, M_AWSIZE}, 0);
      chk("idle_w", {M_WDATA, M_WLAST}, 0);
      chk("idle_strb", M_WSTRB, 0);
    end
  endtask

  task automatic model_edge();
    if (!rstn) begin
      m_own = -1; m_rr = 0; m_awd = 0; m_err = 0;
      return;
    end
    if (m_own < 0) begin
      for (int k = 0; k < N; k++) begin
        int p = (m_rr + k) % N;
        if (aw_on[p]) begin
          m_own = p; m_awd = 0; glog.push_back(p);
          chk("fair", wait_b[p] < N, 1);
          for (int q = 0; q < N; q++) if (q != p && aw_on[q]) wait_b[q]++;
          wait_b[p] = 0;
          break;
        end
      end
    end else if (!m_awd) begin
      if (aw_on[m_own] && M_AWREADY) m_awd = 1;
    end else if (w_on[m_own] && M_WREADY) begin
      bit lst = is_last(m_own);
`ifdef AXI4STREAM_WR_ARB_LENCHK_EN
      if (lst != (beat[m_own] == len[m_own])) m_err = 1;
`endif
      if (lst) begin m_rr = (m_own + 1) % N; m_own = -1; end
    end
  endtask

  task automatic req_edge();
    if (!rstn) begin
      for (int p = 0; p < N; p++) begin act[p] = 0; aw_on[p] = 0; aw_dn[p] = 0; w_on[p] = 0; end
      return;
    end
    for (int p = 0; p < N; p++) begin
      if (aw_on[p] && S_AWREADY[p]) begin aw_on[p] = 0; aw_dn[p] = 1; end
      if (w_on[p] && S_WREADY[p]) begin
        if (p == 1) beats_p1++;
        if (is_last(p)) begin
          act[p] = 0; w_on[p] = 0; aw_dn[p] = 0; seq[p]++; badlast[p] = -1;
        end else begin
          beat[p]++;
          w_on[p] = rnd_w ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
      end else if (act[p] && !w_on[p] && (aw_dn[p] || early[p])) begin
        w_on[p] = rnd_w ? bit'($urandom_range(0, 1)) : 1'b1;
      end
      if (!act[p] && auto_rq) begin
        if (auto_len0) start(p, 0, -1, 0, 1);
        else if ($urandom_range(0, 3) == 0)
          start(p, int'($urandom_range(0, 3)), -1, bit'($urandom_range(0, 1)), 1);
      end
    end
  endtask

  // one cycle: drive at negedge, check, advance both models, cross posedge
  task automatic step();
    drive();
    #1;
    check_outputs();
    model_edge();
    req_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain(string tag, int maxc);
    int c = 0;
    while ((m_own >= 0 || any_act()) && c < maxc) begin step(); c++; end
    chk(tag, (m_own < 0) && !any_act(), 1);
  endtask

  initial begin
    int base;
    for (int p = 0; p < N; p++) begin
      act[p] = 0; aw_on[p] = 0; aw_dn[p] = 0; w_on[p] = 0; early[p] = 0;
      len[p] = 0; siz[p] = 0; beat[p] = 0; seq[p] = 0; badlast[p] = -1; wait_b[p] = 0;
    end
    rstn = 1'b0;
    drive();
    @(posedge clk);
    @(negedge clk);
    step();                       // reset values checked against idle model
    rstn = 1'b1;

    // single requester, port 2, AWLEN=3
    start(2, 3, -1, 0, 1);
    drain("t1_done", 20);
    chk("t1_port", glog[glog.size()-1], 2);

    // all ports continuously, AWLEN=0, from reset
    rstn = 1'b0; step(); rstn = 1'b1;
    base = glog.size();
    auto_rq = 1; auto_len0 = 1;
    for (int p = 0; p < N; p++) start(p, 0, -1, 0, 1);
    for (int c = 0; c < 16; c++) step();
    auto_rq = 0; auto_len0 = 0;
    drain("t2_drain", 40);
    for (int k = 0; k < 5; k++) chk("t2_order", glog[base+k], k % N);

    // W backpressure on port 1
    rdy_mode = 2; tog = 1'b1; beats_p1 = 0;
    start(1, 3, -1, 0, 1);
    drain("t3_done", 30);
    chk("t3_beats", beats_p1, 4);
    rdy_mode = 0;

    // early W on port 3
    start(3, 1, -1, 1, 0);
    step(); step();
    aw_on[3] = 1;
    drain("t4_done", 20);
    chk("t4_port", glog[glog.size()-1], 3);

    // reset in the middle of a 4-beat burst of port 0
    start(0, 3, -1, 0, 1);
    for (int c = 0; c < 4; c++) step();
    chk("t5_mid", beat[0], 2);
    rstn = 1'b0; step(); rstn = 1'b1;
    drive(); #1;
    chk("t5_grant", GRANT_O, 0);
    chk("t5_wvalid", M_WVALID, 0);
    chk("t5_busy", BUSY_O, 0);
    @(negedge clk);
    start(1, 1, -1, 0, 1);
    start(0, 1, -1, 0, 1);
    step(); step();
    chk("t5_ptr0", glog[glog.size()-1], 0);
    drain("t5_drain", 30);

    // randomized traffic with random readies
    rdy_mode = 1; rnd_w = 1; auto_rq = 1;
    for (int c = 0; c < 3000; c++) step();
    auto_rq = 0;
    drain("rnd_drain", 400);
    rdy_mode = 0; rnd_w = 0;

    // early WLAST (beat 2 of AWLEN=3), then a correct burst
    start(2, 3, 2, 0, 1);
    drain("t6_bad", 20);
`ifdef AXI4STREAM_WR_ARB_LENCHK_EN
    chk("t6_err", ERR_O, 1);
`else
    chk("t6_err", ERR_O, 0);
`endif
    start(0, 3, -1, 0, 1);
    drain("t6_good", 20);
    chk("t6_err_held", ERR_O, m_err);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
